// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder operand requester.
// Contents:
//   req_state_e : requester FSM states
//   sum_t       : sum type at the package default operand width
//   wait_width  : width of the latency down-counter for a given ADDR_LAT
package adder_pkg;

  localparam int DEFAULT_LENGTH = 8;
  localparam int DEFAULT_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } req_state_e;

  typedef logic [DEFAULT_LENGTH:0] sum_t;

  // The counter holds values up to lat-1. One bit is always kept so the
  // register exists even when the latency is a single cycle.
  function automatic int wait_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous clear, active-high
//   inc : count enable; the count holds once it reaches all-ones
//   cnt : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/adder_requester.sv
// Initiator side of the adder operand interface.
// An operand pair accepted over req_valid/req_ready is latched, presented
// to the adder with a one-cycle en_addr pulse, and the registered adder sum
// is sampled ADDR_LAT cycles later. The sample is compared with a locally
// computed sum, and the sum plus a mismatch flag are returned over
// rsp_valid/rsp_ready.
// Ports:
//   sig_addr_clock          : clock, rising edge
//   sig_addr_rst            : synchronous reset, active-high
//   req_valid/req_ready     : operand handshake; req_ina/req_inb are the operands
//   en_addr                 : adder enable pulse
//   sig_addr_ina/inb        : latched operands to the adder
//   sig_addr_out            : registered adder sum
//   rsp_valid/rsp_ready     : response handshake; rsp_sum/rsp_err are the payload
//   txn_count               : completed responses (wraps)
//   err_count               : responses flagged in error (saturates)
module adder_requester
  import adder_pkg::*;
#(
  parameter int LENGTH   = DEFAULT_LENGTH,
  parameter int ADDR_LAT = 1,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic              sig_addr_clock,
  input  logic              sig_addr_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LENGTH-1:0] req_ina,
  input  logic [LENGTH-1:0] req_inb,
  output logic              en_addr,
  output logic [LENGTH-1:0] sig_addr_ina,
  output logic [LENGTH-1:0] sig_addr_inb,
  input  logic [LENGTH:0]   sig_addr_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LENGTH:0]   rsp_sum,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int                WAIT_W    = wait_width(ADDR_LAT);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ADDR_LAT - 1);

  req_state_e        r_state;
  req_state_e        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [LENGTH-1:0] r_ina;
  logic [LENGTH-1:0] r_inb;
  logic [LENGTH:0]   r_exp;
  logic [LENGTH:0]   r_sum;
  logic              r_err;
  logic [CNT_W-1:0]  r_txn;
  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_fire;
  logic              w_err_inc;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_capture  = (r_state == WAIT) && (r_wait == '0);
  assign w_rsp_fire = (r_state == RESP) && rsp_ready;
  assign w_err_inc  = w_rsp_fire && r_err;

  // State register
  always_ff @(posedge sig_addr_clock) begin
    if (sig_addr_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_wait == '0) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded handshake and enable outputs
  always_comb begin
    req_ready = 1'b0;
    en_addr   = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready = 1'b1;
      ISSUE:   en_addr   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, latency counter, sum capture and transaction count.
  // A reset drops any transaction in flight, so the response registers are
  // cleared along with the control state.
  always_ff @(posedge sig_addr_clock) begin
    if (sig_addr_rst) begin
      r_ina  <= '0;
      r_inb  <= '0;
      r_exp  <= '0;
      r_wait <= '0;
      r_sum  <= '0;
      r_err  <= 1'b0;
      r_txn  <= '0;
    end else begin
      if (w_accept) begin
        r_ina <= req_ina;
        r_inb <= req_inb;
        r_exp <= {1'b0, req_ina} + {1'b0, req_inb};
      end
      if (r_state == ISSUE) begin
        r_wait <= WAIT_INIT;
      end else if ((r_state == WAIT) && (r_wait != '0)) begin
        r_wait <= r_wait - 1'b1;
      end
      if (w_capture) begin
        r_sum <= sig_addr_out;
        r_err <= (sig_addr_out != r_exp);
      end
      if (w_rsp_fire) begin
        r_txn <= r_txn + 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk(sig_addr_clock),
    .clr(sig_addr_rst),
    .inc(w_err_inc),
    .cnt(err_count)
  );

  assign sig_addr_ina = r_ina;
  assign sig_addr_inb = r_inb;
  assign rsp_sum      = r_sum;
  assign rsp_err      = r_err;
  assign txn_count    = r_txn;

endmodule

// File: tb/tb_adder_requester.sv
module tb_adder_requester;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 1: ADDR_LAT=1, 16-bit counters
  logic       rv1 = 1'b0, rr1 = 1'b1, rdy1, en1, vv1, err1, fault1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, sa1, sb1;
  logic [8:0] out1, sum1;
  logic [15:0] tx1, ec1;

  // DUT 2: ADDR_LAT=2, 3-bit counters so saturation and wrap are reachable
  logic       rv2 = 1'b0, rr2 = 1'b1, rdy2, en2, vv2, err2, fault2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0, sa2, sb2;
  logic [8:0] out2, sum2;
  logic [2:0] tx2, ec2;

  int checks = 0;
  int errors = 0;
  int tx_ref1 = 0, ec_ref1 = 0, tx_ref2 = 0, ec_ref2 = 0;

  adder_requester #(.LENGTH(8), .ADDR_LAT(1), .CNT_W(16)) dut1 (
    .sig_addr_clock(clk), .sig_addr_rst(rst),
    .req_valid(rv1), .req_ready(rdy1), .req_ina(a1), .req_inb(b1),
    .en_addr(en1), .sig_addr_ina(sa1), .sig_addr_inb(sb1), .sig_addr_out(out1),
    .rsp_valid(vv1), .rsp_ready(rr1), .rsp_sum(sum1), .rsp_err(err1),
    .txn_count(tx1), .err_count(ec1)
  );

  adder_requester #(.LENGTH(8), .ADDR_LAT(2), .CNT_W(3)) dut2 (
    .sig_addr_clock(clk), .sig_addr_rst(rst),
    .req_valid(rv2), .req_ready(rdy2), .req_ina(a2), .req_inb(b2),
    .en_addr(en2), .sig_addr_ina(sa2), .sig_addr_inb(sb2), .sig_addr_out(out2),
    .rsp_valid(vv2), .rsp_ready(rr2), .rsp_sum(sum2), .rsp_err(err2),
    .txn_count(tx2), .err_count(ec2)
  );

  // Registered adder models, active-low reset tied to ~rst; a fault makes them return 0.
  logic adder_rst_n;
  assign adder_rst_n = ~rst;
  always @(posedge clk) begin
    if (!adder_rst_n) out1 <= '0;
    else if (en1) out1 <= fault1 ? 9'd0 : ({1'b0, sa1} + {1'b0, sb1});
  end
  always @(posedge clk) begin
    if (!adder_rst_n) out2 <= '0;
    else if (en2) out2 <= fault2 ? 9'd0 : ({1'b0, sa2} + {1'b0, sb2});
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on DUT 1 with rsp_ready high. Cycle indices are relative
  // to the accept cycle n (index 1 = n+1). rsp_cyc stays -1 on timeout.
  task automatic txn1(input logic [7:0] a, input logic [7:0] b,
                      output logic [8:0] s, output logic e,
                      output logic [7:0] oa, output logic [7:0] ob,
                      output int en_cyc, output int rsp_cyc, output int en_pulses);
    rr1 = 1'b1; rv1 = 1'b1; a1 = a; b1 = b;
    s = '0; e = 1'b0; oa = '0; ob = '0;
    en_cyc = -1; rsp_cyc = -1; en_pulses = 0;
    step();
    rv1 = 1'b0;
    for (int k = 1; k <= 20 && rsp_cyc < 0; k++) begin
      if (en1) begin
        en_pulses++;
        if (en_cyc < 0) begin en_cyc = k; oa = sa1; ob = sb1; end
      end
      if (vv1) begin rsp_cyc = k; s = sum1; e = err1; end
      else step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", rdy1); end
    checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_en_addr got %0b want 0", en1); end
    checks++; if (vv1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", vv1); end
    checks++; if (sum1 !== 9'd0) begin errors++; $display("FAIL reset_rsp_sum got %0h want 0", sum1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b want 0", err1); end
    checks++; if (tx1 !== 16'd0) begin errors++; $display("FAIL reset_txn_count got %0d want 0", tx1); end
    checks++; if (ec1 !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", ec1); end
    checks++; if ({sa1, sb1} !== 16'd0) begin errors++; $display("FAIL reset_operands got %0h want 0", {sa1, sb1}); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_req_ready2 got %0b want 1", rdy2); end
    checks++; if ({tx2, ec2} !== 6'd0) begin errors++; $display("FAIL reset_counters2 got %0h want 0", {tx2, ec2}); end
  endtask

  task automatic test_basic();
    logic [8:0] s; logic e; logic [7:0] oa, ob; int ec, rc, np;
    txn1(8'd3, 8'd4, s, e, oa, ob, ec, rc, np);
    tx_ref1++;
    checks++; if (ec !== 1) begin errors++; $display("FAIL basic_en_cycle got %0d want 1", ec); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_en_pulses got %0d want 1", np); end
    checks++; if (oa !== 8'd3 || ob !== 8'd4) begin errors++; $display("FAIL basic_operands got %0d,%0d want 3,4", oa, ob); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL basic_rsp_cycle got %0d want 3", rc); end
    checks++; if (s !== 9'd7) begin errors++; $display("FAIL basic_sum got %0d want 7", s); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %0b want 0", e); end
    checks++; if (tx1 !== 16'(tx_ref1)) begin errors++; $display("FAIL basic_txn_count got %0d want %0d", tx1, tx_ref1); end
  endtask

  task automatic test_edges();
    logic [7:0] ea [2];
    logic [8:0] s, want; logic e; logic [7:0] oa, ob; int ec, rc, np;
    ea[0] = 8'hFF; ea[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      want = (i == 0) ? 9'h1FE : 9'h000;
      txn1(ea[i], ea[i], s, e, oa, ob, ec, rc, np);
      tx_ref1++;
      checks++; if (s !== want) begin errors++; $display("FAIL edge_sum[%0d] got %0h want %0h", i, s, want); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL edge_err[%0d] got %0b want 0", i, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b; logic [8:0] s; logic e; logic [7:0] oa, ob; int ec, rc, np, want;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      want = int'(a) + int'(b);
      txn1(a, b, s, e, oa, ob, ec, rc, np);
      tx_ref1++;
      checks++; if (rc !== 3) begin errors++; $display("FAIL rand_latency[%0d] got %0d want 3", i, rc); end
      checks++; if (s !== 9'(want) || e !== 1'b0) begin errors++; $display("FAIL rand_rsp[%0d] got %0d/%0b want %0d/0", i, s, e, want); end
    end
    checks++; if (tx1 !== 16'(tx_ref1)) begin errors++; $display("FAIL rand_txn_count got %0d want %0d", tx1, tx_ref1); end
  endtask

  task automatic test_fault();
    logic [8:0] s; logic e; logic [7:0] oa, ob; int ec, rc, np;
    fault1 = 1'b1;
    txn1(8'd5, 8'd6, s, e, oa, ob, ec, rc, np);
    fault1 = 1'b0;
    tx_ref1++; ec_ref1++;
    checks++; if (s !== 9'd0) begin errors++; $display("FAIL fault_sum got %0d want 0", s); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL fault_err got %0b want 1", e); end
    checks++; if (ec1 !== 16'(ec_ref1)) begin errors++; $display("FAIL fault_err_count got %0d want %0d", ec1, ec_ref1); end
    checks++; if (tx1 !== 16'(tx_ref1)) begin errors++; $display("FAIL fault_txn_count got %0d want %0d", tx1, tx_ref1); end
  endtask

  task automatic test_backpressure();
    bit seen;
    rr1 = 1'b0; rv1 = 1'b1; a1 = 8'd1; b1 = 8'd2;
    step();
    a1 = 8'd9; b1 = 8'd1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (vv1) seen = 1; else step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_timeout got none want rsp_valid"); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (vv1 !== 1'b1 || sum1 !== 9'd3 || err1 !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b s=%0d want v=1 s=3", k, vv1, sum1); end
      checks++; if (rdy1 !== 1'b0 || en1 !== 1'b0) begin errors++; $display("FAIL bp_quiet[%0d] got rdy=%0b en=%0b want 0,0", k, rdy1, en1); end
      checks++; if (sa1 !== 8'd1 || sb1 !== 8'd2) begin errors++; $display("FAIL bp_operands[%0d] got %0d,%0d want 1,2", k, sa1, sb1); end
    end
    rr1 = 1'b1;
    step();
    checks++; if (rdy1 !== 1'b1 || vv1 !== 1'b0) begin errors++; $display("FAIL bp_idle got rdy=%0b v=%0b want 1,0", rdy1, vv1); end
    step();
    rv1 = 1'b0;
    checks++; if (en1 !== 1'b1 || sa1 !== 8'd9 || sb1 !== 8'd1) begin errors++; $display("FAIL bp_issue got en=%0b %0d,%0d want 1 9,1", en1, sa1, sb1); end
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (vv1) seen = 1; else step();
    end
    checks++; if (!seen || sum1 !== 9'd10 || err1 !== 1'b0) begin errors++; $display("FAIL bp_second got v=%0b s=%0d want 1 10", seen, sum1); end
    step();
    tx_ref1 += 2;
    checks++; if (tx1 !== 16'(tx_ref1)) begin errors++; $display("FAIL bp_txn_count got %0d want %0d", tx1, tx_ref1); end
  endtask

  task automatic test_reset_mid();
    bit leaked;
    rr1 = 1'b1; rv1 = 1'b1; a1 = 8'd7; b1 = 8'd8;
    step();
    rv1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_ref1 = 0; ec_ref1 = 0;
    checks++; if (en1 !== 1'b0 || vv1 !== 1'b0) begin errors++; $display("FAIL mid_outputs got en=%0b v=%0b want 0,0", en1, vv1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL mid_req_ready got %0b want 1", rdy1); end
    checks++; if (tx1 !== 16'd0 || ec1 !== 16'd0) begin errors++; $display("FAIL mid_counters got %0d,%0d want 0,0", tx1, ec1); end
    checks++; if (sum1 !== 9'd0) begin errors++; $display("FAIL mid_rsp_sum got %0d want 0", sum1); end
    leaked = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (vv1 || en1) leaked = 1;
    end
    checks++; if (leaked) begin errors++; $display("FAIL mid_no_response got activity want none"); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4], pb [4];
    int en_t [$];
    logic [8:0] got [$];
    logic ge [$];
    int idx;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
    rr2 = 1'b1; rv2 = 1'b1; a2 = pa[0]; b2 = pb[0]; idx = 0;
    for (int c = 0; c < 80 && got.size() < 4; c++) begin
      step();
      if (en2) begin
        en_t.push_back(c);
        idx++;
        if (idx < 4) begin a2 = pa[idx]; b2 = pb[idx]; end
        else rv2 = 1'b0;
      end
      if (vv2 && rr2) begin got.push_back(sum2); ge.push_back(err2); end
    end
    rv2 = 1'b0;
    step();
    tx_ref2 = 4;
    checks++; if (got.size() != 4 || en_t.size() != 4) begin errors++; $display("FAIL b2b_count got %0d rsp %0d en want 4,4", got.size(), en_t.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== ({1'b0, pa[i]} + {1'b0, pb[i]}) || ge[i] !== 1'b0) begin errors++; $display("FAIL b2b_sum[%0d] got %0d/%0b want %0d/0", i, got[i], ge[i], int'(pa[i]) + int'(pb[i])); end
      end
      if (i > 0 && i < en_t.size()) begin
        checks++; if (en_t[i] - en_t[i-1] != 5) begin errors++; $display("FAIL b2b_gap[%0d] got %0d want 5", i, en_t[i] - en_t[i-1]); end
      end
    end
    checks++; if (tx2 !== 3'(tx_ref2)) begin errors++; $display("FAIL b2b_txn_count got %0d want %0d", tx2, tx_ref2); end
  endtask

  task automatic test_saturate();
    bit seen;
    fault2 = 1'b1; rr2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rv2 = 1'b1;
      a2 = 8'($urandom_range(1, 255));
      b2 = 8'($urandom_range(0, 255));
      step();
      rv2 = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (vv2) seen = 1; else step();
      end
      checks++; if (!seen || sum2 !== 9'd0 || err2 !== 1'b1) begin errors++; $display("FAIL sat_rsp[%0d] got v=%0b s=%0d e=%0b want 1 0 1", i, seen, sum2, err2); end
      step();
      tx_ref2 = (tx_ref2 + 1) % 8;
      if (ec_ref2 < 7) ec_ref2++;
      checks++; if (ec2 !== 3'(ec_ref2) || tx2 !== 3'(tx_ref2)) begin errors++; $display("FAIL sat_counts[%0d] got err=%0d txn=%0d want %0d,%0d", i, ec2, tx2, ec_ref2, tx_ref2); end
    end
    fault2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_random();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_requester.md
Name: adder_requester

Overview:
- Initiator side of the adder operand interface.
- Accepts operand pairs from upstream over a valid/ready handshake and drives them to the adder as a one-cycle en_addr pulse.
- Samples the adder sum after a fixed latency, checks it against an internally computed expected sum, and returns sum plus error flag downstream over valid/ready.
- Sits between the test/control logic and the adder; keeps per-transaction and error counters.

Parameters:
LENGTH, 8, operand width; sum width is LENGTH+1
ADDR_LAT, 1, cycles from the en_addr edge until sig_addr_out is sampled; legal range >=1
CNT_W, 16, width of txn_count and err_count

Ports:
sig_addr_clock  in  1  clock, all logic on rising edge
sig_addr_rst  in  1  reset, synchronous, active-high
req_valid  in  1  upstream operand pair valid
req_ready  out  1  block can accept an operand pair
req_ina  in  LENGTH  operand A
req_inb  in  LENGTH  operand B
en_addr  out  1  adder enable, one-cycle pulse per transaction
sig_addr_ina  out  LENGTH  operand A to adder
sig_addr_inb  out  LENGTH  operand B to adder
sig_addr_out  in  LENGTH+1  registered sum from adder
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_sum  out  LENGTH+1  captured adder sum
rsp_err  out  1  captured sum != zero-extended req_ina+req_inb
txn_count  out  CNT_W  completed responses, wraps
err_count  out  CNT_W  responses with rsp_err=1, saturates at all-ones

Behaviour:
- Reset (sync, high): state IDLE. All outputs 0 except req_ready=1 from the first post-reset cycle. Counters 0. Latched operands 0.
- Reset mid-operation: the transaction is dropped and no response is produced. en_addr and rsp_valid are low the cycle after the reset edge.
- Integration: the adder's active-low reset is tied to ~sig_addr_rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch req_ina/req_inb into sig_addr_ina/inb, compute expected = {1'b0,ina}+{1'b0,inb}, go to ISSUE.
- ISSUE:
  - en_addr=1 for exactly this cycle; req_ready=0.
  - Load wait counter with ADDR_LAT-1, go to WAIT.
- WAIT:
  - en_addr=0. While counter != 0, decrement.
  - At counter==0: capture sig_addr_out into rsp_sum, set rsp_err = (sig_addr_out != expected), go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: txn_count+1 (wraps); if rsp_err, err_count+1 unless all-ones. Go to IDLE.
- Latency, accept edge = cycle n: en_addr high in n+1; sample at end of n+1+ADDR_LAT; rsp_valid from cycle n+2+ADDR_LAT.
- Throughput: one transaction per ADDR_LAT+3 cycles with rsp_ready tied high.
- sig_addr_ina/inb hold the last latched values outside ISSUE; they change only on an accept.
- req_valid outside IDLE is ignored; req_ready=0 there.
- Response handshake and req_valid in the same cycle: the new request is not accepted until the following IDLE cycle.
- Width: sum is LENGTH+1 bits and cannot overflow. Max 2*(2^LENGTH-1), i.e. 0x1FE for LENGTH=8.
- rsp_valid never drops without a handshake, except on reset.

Decomposition:
- Package adder_pkg:
  - enum req_state_e {IDLE, ISSUE, WAIT, RESP}
  - DEFAULT_LENGTH=8, DEFAULT_CNT_W=16
  - typedef sum_t as logic [LENGTH:0], for package-level default width
- One sub-module, sat_counter (parameter W, inputs inc/clr, output cnt), used for err_count. txn_count is a plain wrapping counter inline.

Test Plan:
- Reset, then req 3+4 accepted at cycle n (ADDR_LAT=1), real adder -> en_addr high only in n+1 with ina=3 inb=4; rsp_valid at n+3, rsp_sum=7, rsp_err=0, txn_count=1.
- Req 255+255 (LENGTH=8) -> rsp_sum=0x1FE, rsp_err=0; req 0+0 -> rsp_sum=0, rsp_err=0.
- Faulty adder model returns 0 for 5+6 -> rsp_sum=0, rsp_err=1, err_count=1. Force err_count to 0xFFFF, inject another fault -> err_count stays 0xFFFF, txn_count increments.
- rsp_ready low 10 cycles during RESP with req_valid high and new operands 9+1 -> rsp_valid/rsp_sum stable, req_ready=0, en_addr=0 throughout. After rsp_ready: 9+1 accepted in the next IDLE cycle, rsp_sum=10.
- Reset asserted during WAIT -> next cycle state IDLE, en_addr=0, rsp_valid=0, counters 0, req_ready=1, no response ever emitted for the dropped request.
- ADDR_LAT=2, rsp_ready=1, req_valid=1 continuous with 4 pairs -> en_addr pulses 5 cycles apart, 4 responses with correct sums, txn_count=4.
